// File: rtl/k12a_input_conditioner.sv
// Two-flop synchroniser, shared sample prescaler and per-bit debounce for the k12a switches and buttons.
// Define K12A_INPUT_STICKY_EN to add press_clear / press_latched sticky press flags.
module k12a_input_conditioner #(
  parameter int PRESCALE           = 1000,
  parameter int DEBOUNCE_TICKS     = 16,
  parameter bit BUTTONS_ACTIVE_LOW = 1'b1
) (
  input  logic       sys_clock,
  input  logic       reset_n,
  input  logic [7:0] raw_switches,
  input  logic [7:0] raw_buttons,
`ifdef K12A_INPUT_STICKY_EN
  input  logic [7:0] press_clear,
  output logic [7:0] press_latched,
`endif
  output logic [7:0] switches,
  output logic [7:0] buttons,
  output logic [7:0] button_press,
  output logic       sample_tick
);

  localparam int N  = 16;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] COUNT_LAST    = CW'(DEBOUNCE_TICKS - 1);

  // Lines 7:0 are switches, 15:8 are buttons; all normalised to 1 = active.
  logic [N-1:0]  norm;
  logic [N-1:0]  s1_reg;
  logic [N-1:0]  s2_reg;
  logic [PW-1:0] presc_reg;
  logic          tick_reg;
  logic [N-1:0]  level;
  logic [N-1:0]  flip;
  logic [7:0]    press_reg;

  assign norm = {raw_buttons ^ {8{BUTTONS_ACTIVE_LOW}}, raw_switches};

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= norm;
      s2_reg <= s1_reg;
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      presc_reg <= (presc_reg == PRESCALE_LAST) ? '0 : presc_reg + 1'b1;
      tick_reg  <= (presc_reg == PRESCALE_LAST);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      logic          level_reg;
      logic [CW-1:0] count_reg;

      // Output takes the new level on the tick that completes the disagreeing run.
      assign flip[gi]  = tick_reg && (s2_reg[gi] != level_reg) && (count_reg == COUNT_LAST);
      assign level[gi] = level_reg;

      always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
          level_reg <= 1'b0;
          count_reg <= '0;
        end else if (tick_reg) begin
          if (s2_reg[gi] == level_reg) begin
            count_reg <= '0;
          end else if (flip[gi]) begin
            level_reg <= s2_reg[gi];
            count_reg <= '0;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Pulse is registered alongside the level so it coincides with buttons first reading 1.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      press_reg <= '0;
    end else begin
      press_reg <= flip[15:8] & s2_reg[15:8];
    end
  end

  assign switches     = level[7:0];
  assign buttons      = level[15:8];
  assign button_press = press_reg;
  assign sample_tick  = tick_reg;

`ifdef K12A_INPUT_STICKY_EN
  logic [7:0] latched_reg;

  // A set in the same cycle as a clear wins.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      latched_reg <= '0;
    end else begin
      latched_reg <= (latched_reg & ~press_clear) | press_reg;
    end
  end

  assign press_latched = latched_reg;
`endif

endmodule
